// File: rtl/mmu_pkg.sv
// Shared types and helpers for the MMU result drain stage.
package mmu_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_MMU, DRAIN} drain_state_t;

  localparam int unsigned MMU_DIM = 4;
  localparam int unsigned NUM_PE  = 16;

  // Sign-bit test only: negative zero and negative-signed NaNs also collapse to 0.
  function automatic logic [31:0] relu_fp32(input logic [31:0] w);
    return w[31] ? '0 : w;
  endfunction

endpackage

// File: rtl/mmu_result_drain.sv
// Snapshots the 4x4 MMU results once idle, optionally applies ReLU and
// streams the sixteen words over a valid/ready port.
module mmu_result_drain
  import mmu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PE     = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         relu_en_i,
  input  logic         mmu_busy_i,
  input  logic [127:0] rdata_1_in,
  input  logic [127:0] rdata_2_in,
  input  logic [127:0] rdata_3_in,
  input  logic [127:0] rdata_4_in,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [31:0]  out_data_o,
  output logic [3:0]   out_idx_o,
  output logic         out_last_o,
  output logic         drain_busy_o,
  output logic         done_o,
  output logic         start_drop_o
);

  drain_state_t          state_q, state_d;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] bank_q [NUM_PE];
  logic                  relu_q, done_q, drop_q;
  logic                  capture, relu_load, hs;
  logic [127:0]          rows [MMU_DIM];
  logic [31:0]           word;

  assign rows[0] = rdata_1_in;
  assign rows[1] = rdata_2_in;
  assign rows[2] = rdata_3_in;
  assign rows[3] = rdata_4_in;

  assign hs = out_valid_o & out_ready_i;

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    relu_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          relu_load = 1'b1;
          if (mmu_busy_i) begin
            state_d = WAIT_MMU;
          end else begin
            capture = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      WAIT_MMU: begin
        if (!mmu_busy_i) begin
          capture = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && cnt_q == 4'(NUM_PE - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      relu_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (relu_load) relu_q <= relu_en_i;
      // 4-bit counter wraps to 0 on the PE15 handshake, ready for the next tile.
      if (hs) cnt_q <= cnt_q + 4'd1;
      done_q <= hs & out_last_o;
      drop_q <= start_i & (state_q != IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned k = 0; k < NUM_PE; k++) bank_q[k] <= '0;
    end else if (capture) begin
      // Row bus c carries column c; PE row r sits in the r-th word from the MSB.
      for (int unsigned r = 0; r < MMU_DIM; r++)
        for (int unsigned c = 0; c < MMU_DIM; c++)
          bank_q[r*MMU_DIM + c] <= rows[c][127 - 32*r -: 32];
    end
  end

  assign word         = bank_q[cnt_q];
  assign out_valid_o  = (state_q == DRAIN);
  assign out_data_o   = !out_valid_o ? '0 : (relu_q ? relu_fp32(word) : word);
  assign out_idx_o    = out_valid_o ? cnt_q : '0;
  assign out_last_o   = out_valid_o && (cnt_q == 4'(NUM_PE - 1));
  assign drain_busy_o = (state_q != IDLE);
  assign done_o       = done_q;
  assign start_drop_o = drop_q;

endmodule

// File: tb/tb_mmu_result_drain.sv
// Randomized scoreboard bench for mmu_result_drain.
module tb_mmu_result_drain;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         start_i = 1'b0, relu_en_i = 1'b0, mmu_busy_i = 1'b0;
  logic [127:0] rdata_1_in = '0, rdata_2_in = '0, rdata_3_in = '0, rdata_4_in = '0;
  logic         out_valid_o, out_ready_i = 1'b1;
  logic [31:0]  out_data_o;
  logic [3:0]   out_idx_o;
  logic         out_last_o, drain_busy_o, done_o, start_drop_o;

  mmu_result_drain #(.DATA_WIDTH(32), .NUM_PE(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .relu_en_i(relu_en_i),
    .mmu_busy_i(mmu_busy_i), .rdata_1_in(rdata_1_in), .rdata_2_in(rdata_2_in),
    .rdata_3_in(rdata_3_in), .rdata_4_in(rdata_4_in), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_idx_o(out_idx_o),
    .out_last_o(out_last_o), .drain_busy_o(drain_busy_o), .done_o(done_o),
    .start_drop_o(start_drop_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cur_w [16];
  int          checks = 0;
  int          passes = 0;
  bit          rand_ready = 0;
  bit          pending_done = 0;
  bit          prev_stall = 0;
  logic [31:0] stall_data;
  logic [3:0]  stall_idx;
  logic        stall_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Places PE k's word on its row bus: column k%4 selects the bus, row k/4 the slot from MSB.
  task automatic load_words();
    logic [127:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = '0;
    for (int k = 0; k < 16; k++) b[k % 4][127 - 32*(k/4) -: 32] = cur_w[k];
    rdata_1_in = b[0]; rdata_2_in = b[1]; rdata_3_in = b[2]; rdata_4_in = b[3];
  endtask

  task automatic push_expect(input bit relu);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.data = (relu && cur_w[k][31]) ? 32'h0 : cur_w[k];
      e.idx  = 4'(k);
      e.last = (k == 15);
      sb.push_back(e);
    end
  endtask

  task automatic rand_words();
    for (int k = 0; k < 16; k++) cur_w[k] = $urandom;
    load_words();
  endtask

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic start_tile(input bit relu, input bit busy);
    start_i = 1'b1; relu_en_i = relu; mmu_busy_i = busy;
    if (!busy) push_expect(relu);
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int n, input bit scramble);
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
      if (scramble) begin
        rdata_1_in = {$urandom, $urandom, $urandom, $urandom};
        rdata_3_in = {$urandom, $urandom, $urandom, $urandom};
      end
    end while (!done_o && n < 400);
    if (!done_o) chk("done_timeout", 32'(done_o), 32'h1);
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int n = 0;
    while (!(out_valid_o && out_idx_o == target) && n < 400) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("reach_idx", 32'(out_idx_o), 32'(target));
  endtask

  // Monitor: scoreboard compare on handshake, stall stability, done timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        prev_stall = 0; pending_done = 0;
      end else begin
        if (pending_done) begin
          chk("done_pulse", 32'(done_o), 32'h1);
          pending_done = 0;
        end else if (done_o) begin
          chk("done_spurious", 32'(done_o), 32'h0);
        end
        if (prev_stall && out_valid_o) begin
          chk("stall_data", out_data_o, stall_data);
          chk("stall_idx", 32'(out_idx_o), 32'(stall_idx));
          chk("stall_last", 32'(out_last_o), 32'(stall_last));
        end
        prev_stall = 0;
        if (out_valid_o && out_ready_i) begin
          if (sb.size() == 0) begin
            chk("unexpected_word", 32'(out_idx_o), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("word_data", out_data_o, e.data);
            chk("word_idx", 32'(out_idx_o), 32'(e.idx));
            chk("word_last", 32'(out_last_o), 32'(e.last));
            if (e.last) pending_done = 1;
          end
        end else if (out_valid_o) begin
          prev_stall = 1;
          stall_data = out_data_o; stall_idx = out_idx_o; stall_last = out_last_o;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i); #1;
      out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 16; k++) cur_w[k] = '0;
    #12;
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_busy", 32'(drain_busy_o), 32'h0);
    chk("rst_drop", 32'(start_drop_o), 32'h0);
    chk("rst_last", 32'(out_last_o), 32'h0);
    chk("rst_data", out_data_o, 32'h0);
    chk("rst_idx", 32'(out_idx_o), 32'h0);
    @(posedge clk_i); #1; rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Ramp pattern, consumer always ready: 16 cycles to done.
    for (int k = 0; k < 16; k++) cur_w[k] = 32'h3F80_0000 + 32'(k);
    load_words();
    start_tile(1'b0, 1'b0);
    wait_done(n, 0);
    chk("drain_cycles", 32'(n), 32'd16);
    @(posedge clk_i); #1;

    // ReLU corner values, with and without ReLU.
    cur_w[5] = 32'hBF80_0000; cur_w[6] = 32'h8000_0000; cur_w[7] = 32'h7FC0_0000;
    load_words();
    start_tile(1'b1, 1'b0);
    wait_done(n, 0);
    @(posedge clk_i); #1;
    start_tile(1'b0, 1'b0);
    wait_done(n, 0);
    @(posedge clk_i); #1;

    // MMU busy for 7 cycles; data present at the busy-low edge is captured.
    rand_words();
    start_tile(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("wait_busy", 32'(drain_busy_o), 32'h1);
      chk("wait_novalid", 32'(out_valid_o), 32'h0);
      if (i < 6) begin @(posedge clk_i); #1; end
    end
    rand_words();
    mmu_busy_i = 1'b0;
    push_expect(1'b1);
    wait_done(n, 0);
    @(posedge clk_i); #1;

    // Random stalls, rdata churn during drain.
    rand_ready = 1;
    for (int t = 0; t < 4; t++) begin
      rand_words();
      start_tile(1'($urandom_range(0, 1)), 1'b0);
      wait_done(n, 1);
      @(posedge clk_i); #1;
    end
    rand_ready = 0;
    @(posedge clk_i); #1;

    // Start during drain is dropped; start in the done cycle is accepted.
    rand_words();
    start_tile(1'b0, 1'b0);
    wait_idx(4'd8);
    start_i = 1'b1; mmu_busy_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("start_drop", 32'(start_drop_o), 32'h1);
    @(posedge clk_i); #1;
    chk("start_drop_clr", 32'(start_drop_o), 32'h0);
    wait_done(n, 0);
    rand_words();
    start_tile(1'b1, 1'b0);
    chk("b2b_valid", 32'(out_valid_o), 32'h1);
    wait_done(n, 0);
    @(posedge clk_i); #1;

    // Async reset mid-drain.
    rand_words();
    start_tile(1'b0, 1'b0);
    wait_idx(4'd10);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_o), 32'h0);
    chk("arst_done", 32'(done_o), 32'h0);
    chk("arst_busy", 32'(drain_busy_o), 32'h0);
    sb.delete();
    @(posedge clk_i); #1; rst_i = 1'b1;
    @(posedge clk_i); #1;
    rand_words();
    start_tile(1'b1, 1'b0);
    wait_done(n, 0);
    chk("post_rst_cycles", 32'(n), 32'd16);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
